// File: rtl/adder_bist_checker.sv
// Built-in self-test controller for WIDTH-bit ripple adders: sweeps every {a,b,cin}
// vector, compares {cout,s} against a golden sum, counts mismatches and logs the first one.
module adder_bist_checker #(
    parameter int WIDTH  = 3,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic                 cin,
    input  logic [WIDTH-1:0]     s,
    input  logic                 cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   err_count,
    output logic [2*WIDTH:0]     first_fail_vec,
    output logic                 first_fail_valid
);

    localparam int         VW         = 2*WIDTH + 1;
    localparam int         EW         = 2*WIDTH + 2;
    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [VW-1:0]   r_vec;
    logic [3:0]      r_wait;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [EW-1:0]   r_err_count;
    logic [VW-1:0]   r_first_fail_vec;
    logic            r_first_fail_valid;

    logic [WIDTH:0]  w_golden;
    logic [WIDTH:0]  w_observed;
    logic            w_mismatch;
    logic            w_last_vec;

    // The vector register is the stimulus itself: {a,b,cin} = vec.
    assign a   = r_vec[2*WIDTH:WIDTH+1];
    assign b   = r_vec[WIDTH:1];
    assign cin = r_vec[0];

    assign w_golden   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign w_observed = {cout, s};
    assign w_mismatch = (w_golden != w_observed);
    assign w_last_vec = &r_vec;

    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err_count;
    assign first_fail_vec   = r_first_fail_vec;
    assign first_fail_valid = r_first_fail_valid;

    // NOTE: all state updates use non-blocking assignments so every register samples
    // the pre-edge values of its peers; blocking here would chain updates within one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state            <= S_IDLE;
            r_vec              <= '0;
            r_wait             <= '0;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_pass             <= 1'b0;
            r_err_count        <= '0;
            r_first_fail_vec   <= '0;
            r_first_fail_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_vec              <= '0;
                        r_wait             <= SETTLE_CNT;
                        r_err_count        <= '0;
                        r_first_fail_valid <= 1'b0;
                        r_busy             <= 1'b1;
                        r_done             <= 1'b0;
                        r_pass             <= 1'b0;
                        r_state            <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    r_wait <= r_wait - 4'd1;
                    if (r_wait == 4'd1) begin
                        r_state <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (w_mismatch) begin
                        r_err_count <= r_err_count + EW'(1);
                        if (!r_first_fail_valid) begin
                            r_first_fail_vec   <= r_vec;
                            r_first_fail_valid <= 1'b1;
                        end
                    end
                    // The final vector's own result must count towards pass.
                    if (w_last_vec) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= !w_mismatch && !r_first_fail_valid;
                        r_state <= S_DONE;
                    end else begin
                        r_vec   <= r_vec + VW'(1);
                        r_wait  <= SETTLE_CNT;
                        r_state <= S_WAIT;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_bist_checker.sv
// Bench for adder_bist_checker: adder models with injectable faults, and a per-cycle
// reference derived from elapsed cycles since start and a table of failing vectors.
module tb_adder_bist_checker;

    localparam int N = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, sel;
    logic start1, start3;
    assign start1 = start & ~sel;
    assign start3 = start & sel;

    logic [2:0] a1, b1, s1, a3, b3, s3;
    logic       cin1, cout1, cin3, cout3;
    logic       busy1, done1, pass1, ffv1, busy3, done3, pass3, ffv3;
    logic [7:0] err1, err3;
    logic [6:0] ff1, ff3;

    adder_bist_checker #(.WIDTH(3), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a(a1), .b(b1), .cin(cin1), .s(s1), .cout(cout1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_vec(ff1), .first_fail_valid(ffv1)
    );

    adder_bist_checker #(.WIDTH(3), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .a(a3), .b(b3), .cin(cin3), .s(s3), .cout(cout3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_fail_vec(ff3), .first_fail_valid(ffv3)
    );

    typedef enum int {M_OK, M_COUT0, M_S0, M_RAND, M_DLY} mode_t;
    mode_t      mode;
    logic [3:0] xor_tab [N];
    logic [3:0] d1_1, d2_1, d1_3, d2_3, r1;

    function automatic logic [3:0] add_of(input logic [6:0] v);
        return 4'(v[6:4]) + 4'(v[3:1]) + 4'(v[0]);
    endfunction

    always @(posedge clk) begin
        d1_1 <= add_of({a1, b1, cin1});
        d2_1 <= d1_1;
        d1_3 <= add_of({a3, b3, cin3});
        d2_3 <= d1_3;
    end

    always_comb begin
        r1 = add_of({a1, b1, cin1});
        case (mode)
            M_COUT0: r1[3] = 1'b0;
            M_S0:    r1[0] = 1'b0;
            M_RAND:  r1 = r1 ^ xor_tab[{a1, b1, cin1}];
            M_DLY:   r1 = d2_1;
            default: ;
        endcase
    end
    assign {cout1, s1} = r1;
    assign {cout3, s3} = d2_3;

    logic       o_busy, o_done, o_pass, o_ffv;
    logic [7:0] o_err;
    logic [6:0] o_ff, o_abc;
    assign o_busy = sel ? busy3 : busy1;
    assign o_done = sel ? done3 : done1;
    assign o_pass = sel ? pass3 : pass1;
    assign o_ffv  = sel ? ffv3  : ffv1;
    assign o_err  = sel ? err3  : err1;
    assign o_ff   = sel ? ff3   : ff1;
    assign o_abc  = sel ? {a3, b3, cin3} : {a1, b1, cin1};

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: k = clock edges since the accepted start edge (-1 = idle after reset).
    int         k = -1;
    int         P = 2;
    bit         armed = 1'b0;
    bit         bad [N];
    logic [6:0] prev_ff = '0;
    logic [6:0] e_vec, e_ff;
    logic       e_busy, e_done, e_pass, e_ffv;
    int         e_err;

    function automatic void compute_bad();
        for (int v = 0; v < N; v++) begin
            case (mode)
                M_COUT0: bad[v] = add_of(7'(v)) >= 4'd8;
                M_S0:    bad[v] = add_of(7'(v)) % 2 == 1;
                M_RAND:  bad[v] = xor_tab[v] != 4'd0;
                // Two-cycle-late adder: a vector sampled fewer than two cycles after it was
                // driven still shows the previous vector's sum.
                M_DLY:   bad[v] = (P - 1 < 2) && (v > 0) && (add_of(7'(v)) != add_of(7'(v - 1)));
                default: bad[v] = 1'b0;
            endcase
        end
    endfunction

    function automatic void model_outputs();
        int checked;
        e_err = 0;
        e_ffv = 1'b0;
        e_ff  = prev_ff;
        if (k < 0) begin
            e_vec  = '0;
            e_busy = 1'b0;
            e_done = 1'b0;
        end else begin
            checked = k / P;
            if (checked > N) checked = N;
            e_busy = k < N * P;
            e_done = !e_busy;
            e_vec  = e_busy ? 7'(k / P) : 7'(N - 1);
            for (int v = 0; v < checked; v++) begin
                if (bad[v]) begin
                    if (!e_ffv) begin
                        e_ffv = 1'b1;
                        e_ff  = 7'(v);
                    end
                    e_err++;
                end
            end
        end
        e_pass = e_done && (e_err == 0);
    endfunction

    always @(posedge clk) begin
        P = sel ? 4 : 2;
        if (!rst_n) begin
            k       = -1;
            prev_ff = '0;
            armed   = 1'b1;
        end else if (armed && start && !(k >= 0 && k < N * P)) begin
            model_outputs();
            prev_ff = e_ff;
            compute_bad();
            k = 0;
        end else if (k >= 0 && k < N * P) begin
            k++;
        end
        #1;
        if (armed) begin
            model_outputs();
            check("vec",  o_abc,  e_vec);
            check("busy", o_busy, e_busy);
            check("done", o_done, e_done);
            check("pass", o_pass, e_pass);
            check("err_count", o_err, e_err);
            check("ff_valid",  o_ffv, e_ffv);
            check("ff_vec",    o_ff,  e_ff);
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input bit poke, output int n);
        n = 0;
        while (!o_done && n < limit) begin
            @(negedge clk);
            n++;
            start = poke && (n == 10 || n == 100);
        end
        start = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle_gap();
        repeat ($urandom_range(0, 7)) @(negedge clk);
    endtask

    int n;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sel   = 1'b0;
        mode  = M_OK;
        for (int v = 0; v < N; v++) xor_tab[v] = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_done", o_done, 1'b0);

        // Correct adder, with start pulses during the sweep that must be ignored.
        pulse_start();
        wait_done(400, 1'b1, n);
        check("lat_s1", n, 256);
        check("ok_pass", o_pass, 1'b1);
        check("ok_err", o_err, 8'd0);
        check("ok_ffv", o_ffv, 1'b0);
        check("ok_abc_end", o_abc, 7'h7F);

        // Restart straight from DONE.
        idle_gap();
        pulse_start();
        check("restart_done", o_done, 1'b0);
        check("restart_err", o_err, 8'd0);
        wait_done(400, 1'b0, n);
        check("lat_restart", n, 256);
        check("restart_pass", o_pass, 1'b1);

        // cout stuck at 0.
        idle_gap();
        mode = M_COUT0;
        pulse_start();
        wait_done(400, 1'b0, n);
        check("cout0_err", o_err, 8'd64);
        check("cout0_ff", o_ff, 7'h0F);
        check("cout0_pass", o_pass, 1'b0);

        // s[0] stuck at 0.
        idle_gap();
        mode = M_S0;
        pulse_start();
        wait_done(400, 1'b0, n);
        check("s0_err", o_err, 8'd64);
        check("s0_ff", o_ff, 7'h01);
        check("s0_ffv", o_ffv, 1'b1);
        check("s0_pass", o_pass, 1'b0);

        // Random per-vector corruption.
        for (int r = 0; r < 3; r++) begin
            idle_gap();
            mode = M_RAND;
            for (int v = 0; v < N; v++)
                xor_tab[v] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            pulse_start();
            wait_done(400, 1'b0, n);
            check("rand_lat", n, 256);
        end

        // Reset in the middle of a sweep.
        idle_gap();
        mode = M_OK;
        pulse_start();
        repeat (49) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_busy", o_busy, 1'b0);
        check("mid_rst_abc", o_abc, 7'h00);
        check("mid_rst_err", o_err, 8'd0);
        pulse_start();
        wait_done(400, 1'b0, n);
        check("post_rst_lat", n, 256);
        check("post_rst_pass", o_pass, 1'b1);

        // Two-cycle adder with only one settle cycle.
        do_reset(3);
        mode = M_DLY;
        pulse_start();
        wait_done(400, 1'b0, n);
        check("dly1_pass", o_pass, 1'b0);
        check("dly1_err_nonzero", o_err != 8'd0, 1'b1);

        // Same delayed adder with three settle cycles.
        @(negedge clk);
        rst_n = 1'b0;
        sel   = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        wait_done(800, 1'b0, n);
        check("dly3_lat", n, 512);
        check("dly3_pass", o_pass, 1'b1);
        check("dly3_err", o_err, 8'd0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_bist_checker.md
Name: adder_bist_checker

Overview:
- Synthesizable built-in self-test controller for the ripple adders in the structural library (adder_3_bit and wider variants).
- Acts as the opposite end of the adder interface: drives a/b/cin into the adder under test, samples s/cout, and checks them against an internal golden sum.
- Sweeps all 2^(2*WIDTH+1) input vectors, counts mismatches and records the first failing vector.
- Sits beside the adder in a test wrapper and replaces the hand-written stimulus bench on silicon or FPGA.

Parameters:
- WIDTH, 3, operand width; must match the adder under test.
- SETTLE, 1, cycles to wait after driving a vector before sampling. Legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  begin a sweep; sampled only in IDLE or DONE
- a  output  WIDTH  operand A to the adder under test
- b  output  WIDTH  operand B to the adder under test
- cin  output  1  carry-in to the adder under test
- s  input  WIDTH  sum from the adder under test
- cout  input  1  carry-out from the adder under test
- busy  output  1  sweep in progress
- done  output  1  sweep complete; results valid
- pass  output  1  done and zero mismatches
- err_count  output  2*WIDTH+2  number of mismatching vectors
- first_fail_vec  output  2*WIDTH+1  {a,b,cin} of the first mismatch
- first_fail_valid  output  1  first_fail_vec holds a captured vector

Behaviour:
- Reset, when rst_n=0 at a clock edge:
  - state=IDLE
  - a, b, cin, busy, done, pass, err_count, first_fail_vec and first_fail_valid all 0
  - Reset mid-sweep aborts the sweep immediately and discards all results.
- Vector index vec has 2*WIDTH+1 bits and maps as {a,b,cin}=vec: cin=vec[0], b=vec[WIDTH:1], a=vec[2*WIDTH:WIDTH+1].
- a, b and cin are registered outputs driven directly from vec.
- Golden result is the (WIDTH+1)-bit value a+b+cin, zero-extended. It is compared against {cout,s}.
- FSM states are IDLE, WAIT, CHECK and DONE.
  - IDLE: on start=1: vec<=0, wait counter<=SETTLE, err_count<=0, first_fail_valid<=0, busy<=1, go to WAIT.
  - WAIT: lasts exactly SETTLE cycles; decrement the counter; go to CHECK after the last cycle.
  - CHECK: one cycle. Compare using the registered a/b/cin and the live s/cout.
    - On mismatch: err_count<=err_count+1. If first_fail_valid=0, capture first_fail_vec<=vec and set first_fail_valid<=1.
    - If vec is all-ones: busy<=0, done<=1, pass<=(no mismatch in the whole sweep, including this vector), go to DONE.
    - Otherwise: vec<=vec+1, wait counter<=SETTLE, go to WAIT.
  - DONE: results are held stable. start=1 clears done/pass/err_count/first_fail_valid and restarts exactly as from IDLE.
- start is ignored while busy=1.
- err_count cannot overflow: its maximum is 2^(2*WIDTH+1), which fits in 2*WIDTH+2 bits.
- vec never wraps; the sweep ends at the all-ones vector.
- Latency: each vector takes SETTLE+1 cycles. done rises 2^(2*WIDTH+1)*(SETTLE+1) cycles after the start edge. Default: 128*2 = 256 cycles.
- pass=1 only while done=1; it is 0 at all other times.

Test Plan:
- Connect a behavioural correct adder (WIDTH=3, SETTLE=1) and pulse start: busy high for 256 cycles, then done=1, pass=1, err_count=0, first_fail_valid=0; a/b/cin end at 3'b111/3'b111/1.
- Force cout stuck at 0: err_count=64 (vectors with a+b+cin>=8), first_fail_vec=7'h0F (a=0, b=7, cin=1), pass=0.
- Force s[0] stuck at 0: err_count=64, first_fail_vec=7'h01, first_fail_valid=1, pass=0.
- Pulse start again at cycles 10 and 100 of a running sweep: both pulses ignored; done still rises at cycle 256. Then pulse start while in DONE: done/pass/err_count clear next cycle and a full new sweep completes.
- Drive rst_n=0 for one cycle at cycle 50 of a sweep: next cycle all outputs 0 and state IDLE. A fresh start then completes normally with pass=1.
- Set SETTLE=3 and model the adder with a 2-cycle output delay: pass=1 and done rises at cycle 512. With SETTLE=1 and the same delayed model, pass=0 and err_count is nonzero.
